// File: rtl/div_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_share_pkg
//  Purpose  : Shared types, constants and helpers for the shared-divider
//             controller (FSM states, requester id, overflow detection).
//  Revision : 1.0 - initial release
// ============================================================================
package div_share_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

  // True when the low n bits encode MIN / -1, the only signed quotient that
  // does not fit in n bits. Operands are passed zero-extended to 64 bits so
  // one function serves every width.
  function automatic logic is_div_ovf(input logic [63:0] dividend,
                                      input logic [63:0] divisor,
                                      input int          n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < n) begin
        if (!divisor[i]) r = 1'b0;
        if (i == n - 1) begin
          if (!dividend[i]) r = 1'b0;
        end else if (dividend[i]) begin
          r = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_share_div.sv
`default_nettype none
// ============================================================================
//  Module   : Div
//  Purpose  : Combinational signed divider. Quotient truncates toward zero,
//             remainder carries the sign of the dividend. MIN / -1 wraps to
//             MIN with remainder 0; a zero divisor yields q=0, r=dividend.
//  Revision : 1.0 - initial release
// ============================================================================
module Div
  import div_share_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] dividendo_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] cociente_o,
  output logic [N-1:0] residuo_o
);

  // Special cases are resolved explicitly so the native operators never see
  // an undefined or overflowing operand pair.
  always_comb begin
    cociente_o = '0;
    residuo_o  = dividendo_i;
    if (divisor_i == '0) begin
      cociente_o = '0;
      residuo_o  = dividendo_i;
    end else if (is_div_ovf(64'(dividendo_i), 64'(divisor_i), N)) begin
      cociente_o = dividendo_i;
      residuo_o  = '0;
    end else begin
      cociente_o = $signed(dividendo_i) / $signed(divisor_i);
      residuo_o  = $signed(dividendo_i) % $signed(divisor_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_share_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-way round-robin grant. The prio requester
//             wins when valid, otherwise the other one is granted.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import div_share_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               prio_i,
  output logic               grant_valid_o,
  output logic               grant_id_o
);

  // Pick prio when it is asking, else fall back to the other requester.
  always_comb begin
    grant_valid_o = |req_valid_i;
    grant_id_o    = req_valid_i[prio_i] ? prio_i : ~prio_i;
  end

endmodule
`default_nettype wire

// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_share_ctrl
//  Purpose  : Shares one combinational signed divider between two
//             requesters: round-robin grant, operand latch, one execute
//             cycle, then a held valid/ready response tagged with the id.
//  Options  : DIV_ZERO_CHECK_EN - divisor 0 bypasses EXEC and reports err.
//  Revision : 1.0 - initial release
// ============================================================================
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*N-1:0]       req_dividendo,
  input  logic [2*N-1:0]       req_divisor,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [N-1:0]         rsp_cociente,
  output logic [N-1:0]         rsp_residuo,
  output logic                 rsp_ovf,
  output logic                 rsp_err,
  output logic                 busy
);

  state_t        state_q, state_d;
  req_id_t       prio_q, prio_d;
  req_id_t       id_q, id_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          ovf_q, ovf_d;
`ifdef DIV_ZERO_CHECK_EN
  logic          err_q, err_d;
`endif

  logic          grant_valid;
  req_id_t       grant_id;
  logic [N-1:0]  sel_dvd;
  logic [N-1:0]  sel_dvs;
  logic [N-1:0]  div_q;
  logic [N-1:0]  div_r;

  rr_arb2 u_arb (
    .req_valid_i   (req_valid),
    .prio_i        (prio_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // The divider only ever sees latched operands, never the live request bus.
  Div #(.N(N)) u_div (
    .dividendo_i (dvd_q),
    .divisor_i   (dvs_q),
    .cociente_o  (div_q),
    .residuo_o   (div_r)
  );

  assign sel_dvd = grant_id ? req_dividendo[2*N-1:N] : req_dividendo[N-1:0];
  assign sel_dvs = grant_id ? req_divisor[2*N-1:N]   : req_divisor[N-1:0];

  // Next-state and grant logic; registers hold unless a state moves them.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
`ifdef DIV_ZERO_CHECK_EN
    err_d     = err_q;
`endif
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid && !rst) begin
          req_ready[grant_id] = 1'b1;
        end
        if (grant_valid) begin
          id_d = grant_id;
`ifdef DIV_ZERO_CHECK_EN
          if (sel_dvs == '0) begin
            // Divider inputs keep their old values on the bypass path.
            quo_d   = '0;
            rem_d   = sel_dvd;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            dvd_d   = sel_dvd;
            dvs_d   = sel_dvs;
            state_d = EXEC;
          end
`else
          dvd_d   = sel_dvd;
          dvs_d   = sel_dvs;
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        quo_d   = div_q;
        rem_d   = div_r;
        ovf_d   = is_div_ovf(64'(dvd_q), 64'(dvs_q), N);
`ifdef DIV_ZERO_CHECK_EN
        err_d   = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
`ifdef DIV_ZERO_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign rsp_id       = id_q;
  assign rsp_cociente = quo_q;
  assign rsp_residuo  = rem_q;
  assign rsp_ovf      = ovf_q;
`ifdef DIV_ZERO_CHECK_EN
  assign rsp_err      = err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_share_ctrl
//  Purpose  : Directed self-checking bench for div_share_ctrl (N=8).
//  Options  : DIV_ZERO_CHECK_EN selects the divide-by-zero bypass checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_ctrl;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_dividendo;
  logic [2*N-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [N-1:0]   rsp_cociente;
  logic [N-1:0]   rsp_residuo;
  logic           rsp_ovf;
  logic           rsp_err;
  logic           busy;

  int nvec = 0;
  int nmis = 0;

  div_share_ctrl #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividendo (req_dividendo),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_cociente  (rsp_cociente),
    .rsp_residuo   (rsp_residuo),
    .rsp_ovf       (rsp_ovf),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int who, input logic [7:0] a, input logic [7:0] b);
    req_dividendo[who*N +: N] = a;
    req_divisor[who*N +: N]   = b;
  endtask

  // One request through the normal IDLE->EXEC->RESP path with rsp_ready=1.
  task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic eovf,
                        input logic check_qr, input string tag);
    logic [1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[who] = 1'b1;
    set_ops(who, a, b);
    req_valid = exp_rdy;
    #1 chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".exec_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".id"}, 32'(rsp_id), 32'(who));
    if (check_qr) begin
      chk({tag, ".q"}, 32'(rsp_cociente), 32'(eq));
      chk({tag, ".r"}, 32'(rsp_residuo), 32'(er));
    end
    chk({tag, ".ovf"}, 32'(rsp_ovf), 32'(eovf));
    chk({tag, ".err"}, 32'(rsp_err), 32'd0);
    @(negedge clk);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] exp_q [3];
  logic [7:0] exp_r [3];
  logic       exp_id[3];

  initial begin
    rst           = 1'b1;
    req_valid     = 2'b11;
    req_dividendo = '0;
    req_divisor   = '0;
    rsp_ready     = 1'b1;

    // Reset held for three cycles with both requesters asking.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.req_ready", 32'(req_ready), 32'd0);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
    end
    chk("rst.outs", {26'd0, rsp_id, rsp_ovf, rsp_err, 1'b0, 2'b00},
        32'd0);
    chk("rst.q", 32'(rsp_cociente), 32'd0);
    chk("rst.r", 32'(rsp_residuo), 32'd0);
    rst = 1'b0;
    #1 chk("rel.req_ready", 32'(req_ready), 32'd1);
    // Withdraw before any grant edge: no effect expected.
    req_valid = 2'b00;
    @(negedge clk);
    chk("rel.idle", 32'(busy), 32'd0);

    run_op(0, 8'd15, 8'd2, 8'd7, 8'd1, 1'b0, 1'b1, "op15_2");
    run_op(0, 8'd0,  8'd1, 8'd0, 8'd0, 1'b0, 1'b1, "op0_1");

    // Backpressure: req1 2/-1 with the consumer stalled for 5 cycles.
    rsp_ready = 1'b0;
    set_ops(1, 8'd2, 8'hFF);
    req_valid = 2'b10;
    #1 chk("bp.ready", 32'(req_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("bp.exec_valid", 32'(rsp_valid), 32'd0);
    set_ops(0, 8'd9, 8'd3);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", 32'(rsp_valid), 32'd1);
      chk("bp.q", 32'(rsp_cociente), 32'hFE);
      chk("bp.r", 32'(rsp_residuo), 32'd0);
      chk("bp.id", 32'(rsp_id), 32'd1);
      chk("bp.busy", 32'(busy), 32'd1);
      chk("bp.req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.done_valid", 32'(rsp_valid), 32'd0);
    chk("bp.done_busy", 32'(busy), 32'd0);

    // Contention: prio is 0 after the req1 response, so 0,1,0.
    set_ops(0, 8'hF1, 8'd2);
    set_ops(1, 8'hFE, 8'hFF);
    exp_id[0] = 1'b0; exp_q[0] = 8'hF9; exp_r[0] = 8'hFF;
    exp_id[1] = 1'b1; exp_q[1] = 8'd2;  exp_r[1] = 8'd0;
    exp_id[2] = 1'b0; exp_q[2] = 8'hF9; exp_r[2] = 8'hFF;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) @(negedge clk);
      chk("cont.valid", 32'(rsp_valid), 32'd1);
      chk("cont.id", 32'(rsp_id), 32'(exp_id[k]));
      chk("cont.q", 32'(rsp_cociente), 32'(exp_q[k]));
      chk("cont.r", 32'(rsp_residuo), 32'(exp_r[k]));
      if (k == 2) req_valid = 2'b00;
      @(negedge clk);
    end
    chk("cont.idle", 32'(busy), 32'd0);

    run_op(0, 8'h80, 8'hFF, 8'h80, 8'd0, 1'b1, 1'b1, "ovf");

    // Divide by zero from requester 1.
`ifdef DIV_ZERO_CHECK_EN
    set_ops(1, 8'd15, 8'd0);
    req_valid = 2'b10;
    #1 chk("dz.ready", 32'(req_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("dz.valid", 32'(rsp_valid), 32'd1);
    chk("dz.id", 32'(rsp_id), 32'd1);
    chk("dz.err", 32'(rsp_err), 32'd1);
    chk("dz.ovf", 32'(rsp_ovf), 32'd0);
    chk("dz.q", 32'(rsp_cociente), 32'd0);
    chk("dz.r", 32'(rsp_residuo), 32'd15);
    @(negedge clk);
    chk("dz.idle", 32'(busy), 32'd0);
`else
    run_op(1, 8'd15, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "dz");
`endif

    // Reset during EXEC drops the transaction.
    set_ops(0, 8'd15, 8'd2);
    req_valid = 2'b01;
    #1 chk("mid.ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("mid.exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid.rst_busy", 32'(busy), 32'd0);
    chk("mid.rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid.no_valid", 32'(rsp_valid), 32'd0);
      chk("mid.idle", 32'(busy), 32'd0);
    end
    req_valid = 2'b11;
    #1 chk("mid.next_grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
